conv_encoder: RTL and testbench
===============================

CONV_ENCODER -- requirements
Module: conv_encoder

Interface
REQ-001 Parameter DATA_LEN, default 13: number of information bits per frame.
REQ-002 Parameter TAIL_LEN, default 2 (K-1): number of zero flush bits appended per frame; DATA_LEN+TAIL_LEN = 15 symbols per frame, matching the decoder traceback length.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; one clock, asynchronous and active-high.
REQ-005 data_i  input  DATA_LEN  frame payload; bit DATA_LEN-1 is encoded first (MSB-first).
REQ-006 valid_i  input  1  payload valid.
REQ-007 ready_o  output  1  encoder accepts a payload this cycle.
REQ-008 sym_o  output  2  code symbol; sym_o[1]=c0 (G0=111), sym_o[0]=c1 (G1=101).
REQ-009 sym_valid_o  output  1  sym_o valid.
REQ-010 sym_ready_i  input  1  downstream accepts the symbol.
REQ-011 frame_start_o  output  1  high with the first symbol of a frame.
REQ-012 frame_end_o  output  1  high with the last (tail) symbol of a frame.

Function
REQ-013 States: IDLE, ENCODE, FLUSH.
- IDLE->ENCODE on valid_i&&ready_o.
- ENCODE->FLUSH on transfer of data symbol DATA_LEN.
- FLUSH->IDLE on transfer of the final tail symbol.
REQ-014 ready_o = 1 only in IDLE; valid_i in other states is ignored and the payload is not captured.
REQ-015 On acceptance: payload latched into a shift register, trellis state cleared to S0, symbol counter cleared.
REQ-016 Trellis state s[1:0] = {u(t-1), u(t-2)}; next state = {u, s[1]}.
REQ-017 Symbol outputs: c0 = u^s[1]^s[0], c1 = u^s[0].
REQ-018 Input bit u: in ENCODE, current shift-register MSB; in FLUSH, 0. After TAIL_LEN tail bits the trellis returns to S0.
REQ-019 Output stage is a registered valid/ready slot that loads a new symbol when !sym_valid_o || sym_ready_i; a transfer occurs when sym_valid_o && sym_ready_i.
REQ-020 sym_o, frame_start_o and frame_end_o are held stable while sym_valid_o=1 && sym_ready_i=0; symbols are never dropped or duplicated.
REQ-021 Latency: first symbol appears with sym_valid_o=1 one cycle after the acceptance edge.
REQ-022 Throughput: one symbol per cycle while sym_ready_i=1; exactly DATA_LEN+TAIL_LEN transfers per frame.
REQ-023 ready_o rises in the cycle after the final transfer, giving a minimum one-cycle gap between frames.
REQ-024 Symbol counter width = $clog2(DATA_LEN+TAIL_LEN) and does not wrap within a frame.
REQ-025 frame_start_o and frame_end_o are both valid only when sym_valid_o=1.

Reset
REQ-026 While rst=1, the following hold:
- state=IDLE, trellis state=S0, shift register=0, counter=0.
- sym_o=2'b00, sym_valid_o=0, frame_start_o=0, frame_end_o=0.
- ready_o=0.
REQ-027 ready_o=1 from the first clk edge after rst deasserts.
REQ-028 Reset mid-frame abandons the frame; the next accepted frame encodes from S0 with no residue.

Structure
REQ-029 Shared package viterbi_pkg holds constant_len K=3, NUM_STATES=4, G0=3'b111, G1=3'b101, TAIL_LEN=2 and the state encoding, and is shared with the decoder (branch metric, path metric, traceback).
REQ-030 Optional sub-module conv_enc_core: combinational next-state and symbol function of (u, s); the FSM, counters and output slot stay in conv_encoder.

Verification
REQ-031 data_i=13'h0000, sym_ready_i=1 -> 15 symbols, all 2'b00; frame_start_o on symbol 1, frame_end_o on symbol 15.
REQ-032 data_i=13'h1000 -> symbols 11,10,11, then twelve 00.
REQ-033 data_i=13'h1FFF -> symbols 11,01, then eleven 10, then tail 01,11; trellis ends in S0.
REQ-034 sym_ready_i low for 3 cycles at symbol 6 -> sym_o held constant; sequence identical to the unstalled run.
REQ-035 rst pulsed during symbol 5, then data_i=13'h1000 -> all outputs zero during reset, ready_o=1 after release; output exactly per REQ-032.
REQ-036 valid_i held high with a new payload during a frame -> payload not captured; second frame starts one cycle after frame_end_o transfer.

Source files
------------

// File: rtl/viterbi_pkg.sv
// Constants and encodings shared by the rate-1/2, K=3 convolutional encoder
// and the Viterbi decoder (branch metric, path metric, traceback).
package viterbi_pkg;

  localparam int K          = 3;
  localparam int NUM_STATES = 4;
  localparam int TAIL_LEN   = K - 1;

  localparam logic [K-1:0] G0 = 3'b111;
  localparam logic [K-1:0] G1 = 3'b101;

  // Trellis state is {u(t-1), u(t-2)}
  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } trellis_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ENCODE = 2'b01,
    FLUSH  = 2'b10
  } enc_state_t;

  // Code symbol {c0, c1} for input bit u leaving trellis state s
  function automatic logic [1:0] code_sym(input logic u, input logic [1:0] s);
    logic [K-1:0] taps;
    taps = {u, s};
    return {^(taps & G0), ^(taps & G1)};
  endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Combinational trellis step: code symbol and next state for input bit u
// leaving state s.
module conv_enc_core
  import viterbi_pkg::*;
(
  input  logic       u,
  input  logic [1:0] s,
  output logic [1:0] sym,
  output logic [1:0] s_next
);

  assign sym    = code_sym(u, s);
  assign s_next = {u, s[1]};

endmodule

// File: rtl/conv_encoder.sv
// Frame-based rate-1/2 K=3 convolutional encoder: MSB-first payload plus
// zero tail, one symbol per cycle through a registered valid/ready slot.
module conv_encoder #(
  parameter int DATA_LEN = 13,
  parameter int TAIL_LEN = viterbi_pkg::TAIL_LEN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_LEN-1:0] data_i,
  input  logic                valid_i,
  output logic                ready_o,
  output logic [1:0]          sym_o,
  output logic                sym_valid_o,
  input  logic                sym_ready_i,
  output logic                frame_start_o,
  output logic                frame_end_o
);

  import viterbi_pkg::*;

  localparam int SYM_TOTAL = DATA_LEN + TAIL_LEN;
  localparam int CNT_W     = $clog2(SYM_TOTAL);

  localparam logic [CNT_W-1:0] CNT_DATA  = CNT_W'(DATA_LEN);
  localparam logic [CNT_W-1:0] CNT_TOTAL = CNT_W'(SYM_TOTAL);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SYM_TOTAL - 1);

  enc_state_t          state_p0, state_d;
  logic [DATA_LEN-1:0] sr_p0;
  logic [1:0]          trellis_p0;
  logic [CNT_W-1:0]    cnt_p0;
  logic                init_p0;

  logic [1:0]          sym_p1;
  logic                vld_p1;
  logic                start_p1;
  logic                end_p1;

  logic                accept;
  logic                slot_free;
  logic                xfer;
  logic                gen;
  logic                u;
  logic [1:0]          sym_nxt;
  logic [1:0]          trellis_nxt;

  // ready_o is held low until the first edge after reset release
  assign ready_o   = (state_p0 == IDLE) && init_p0;
  assign accept    = valid_i && ready_o;
  assign slot_free = !vld_p1 || sym_ready_i;
  assign xfer      = vld_p1 && sym_ready_i;
  assign gen       = (state_p0 != IDLE) && (cnt_p0 < CNT_TOTAL) && slot_free;

  // Shift register fills with zeros, so the tail bits are zero either way
  assign u = (state_p0 == ENCODE && cnt_p0 < CNT_DATA) ? sr_p0[DATA_LEN-1] : 1'b0;

  conv_enc_core u_core (
    .u      (u),
    .s      (trellis_p0),
    .sym    (sym_nxt),
    .s_next (trellis_nxt)
  );

  // While the slot is full it holds symbol number cnt_p0, so the frame
  // phase advances on the transfer of that symbol rather than on its load.
  always_comb begin
    state_d = state_p0;
    unique case (state_p0)
      IDLE:    if (accept) state_d = ENCODE;
      ENCODE:  if (xfer && cnt_p0 == CNT_DATA) state_d = FLUSH;
      FLUSH:   if (xfer && cnt_p0 == CNT_TOTAL) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage p0: frame control, payload shift register and trellis state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p0   <= IDLE;
      sr_p0      <= '0;
      trellis_p0 <= S0;
      cnt_p0     <= '0;
      init_p0    <= 1'b0;
    end else begin
      init_p0  <= 1'b1;
      state_p0 <= state_d;
      if (accept) begin
        sr_p0      <= data_i;
        trellis_p0 <= S0;
        cnt_p0     <= '0;
      end else if (gen) begin
        sr_p0      <= sr_p0 << 1;
        trellis_p0 <= trellis_nxt;
        cnt_p0     <= cnt_p0 + 1'b1;
      end
    end
  end

  // Stage p1: registered output slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sym_p1   <= 2'b00;
      vld_p1   <= 1'b0;
      start_p1 <= 1'b0;
      end_p1   <= 1'b0;
    end else if (slot_free) begin
      vld_p1   <= gen;
      start_p1 <= gen && (cnt_p0 == '0);
      end_p1   <= gen && (cnt_p0 == CNT_LAST);
      if (gen) sym_p1 <= sym_nxt;
    end
  end

  assign sym_o         = sym_p1;
  assign sym_valid_o   = vld_p1;
  assign frame_start_o = start_p1;
  assign frame_end_o   = end_p1;

endmodule

// File: tb/tb_conv_encoder.sv
// Directed bench for conv_encoder: table of payloads with expected symbol
// streams, plus busy-input, stall and mid-frame reset sequences.
module tb_conv_encoder;

  localparam int DATA_LEN = 13;
  localparam int TAIL_LEN = 2;
  localparam int NSYM     = DATA_LEN + TAIL_LEN;

  logic                clk = 1'b0;
  logic                rst;
  logic [DATA_LEN-1:0] data_i;
  logic                valid_i;
  logic                ready_o;
  logic [1:0]          sym_o;
  logic                sym_valid_o;
  logic                sym_ready_i;
  logic                frame_start_o;
  logic                frame_end_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  conv_encoder #(.DATA_LEN(DATA_LEN), .TAIL_LEN(TAIL_LEN)) dut (
    .clk           (clk),
    .rst           (rst),
    .data_i        (data_i),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .sym_o         (sym_o),
    .sym_valid_o   (sym_valid_o),
    .sym_ready_i   (sym_ready_i),
    .frame_start_o (frame_start_o),
    .frame_end_o   (frame_end_o)
  );

  typedef struct {
    logic [DATA_LEN-1:0] d;
    int                  stall_at;
    logic [2*NSYM-1:0]   exp;
    string               name;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Offer payload d, then collect the full frame, checking every symbol and
  // its start/end flags. stall_at>0 holds sym_ready_i low for three cycles
  // while that symbol is on the output. hold_valid keeps valid_i high with a
  // different payload for the whole frame.
  task automatic run_frame(input logic [DATA_LEN-1:0] d, input int stall_at,
                           input logic [2*NSYM-1:0] exp, input bit hold_valid,
                           input string name);
    int t;
    int got;
    int stalls;
    logic [3:0] held;
    logic [3:0] want;
    logic r;
    t = 0;
    while (!ready_o && t < 40) begin
      @(negedge clk);
      t++;
    end
    check({name, " ready"}, 32'(ready_o), 1);
    valid_i     = 1'b1;
    data_i      = d;
    sym_ready_i = 1'b1;
    @(negedge clk);
    check({name, " no symbol at accept"}, 32'(sym_valid_o), 0);
    if (hold_valid) data_i = ~d;
    else valid_i = 1'b0;
    @(negedge clk);
    check({name, " first symbol latency"}, 32'(sym_valid_o), 1);
    got    = 0;
    stalls = 0;
    held   = '0;
    t      = 0;
    while (got < NSYM && t < 100) begin
      r = 1'b1;
      if (sym_valid_o) begin
        if (got == stall_at - 1 && stalls < 3) begin
          if (stalls == 0) held = {sym_o, frame_start_o, frame_end_o};
          else check({name, " held during stall"}, 32'({sym_o, frame_start_o, frame_end_o}), 32'(held));
          r = 1'b0;
          stalls++;
        end else begin
          want = {exp[2*NSYM-1-2*got -: 2], got == 0, got == NSYM - 1};
          check($sformatf("%s sym%0d", name, got + 1),
                32'({sym_o, frame_start_o, frame_end_o}), 32'(want));
          if (got == NSYM - 1) check({name, " ready low before last xfer"}, 32'(ready_o), 0);
          got++;
        end
      end
      sym_ready_i = r;
      @(negedge clk);
      t++;
    end
    sym_ready_i = 1'b1;
    check({name, " symbol count"}, 32'(got), NSYM);
    check({name, " ready after last xfer"}, 32'(ready_o), 1);
    check({name, " slot empty after frame"}, 32'(sym_valid_o), 0);
  endtask

  initial begin
    int got;
    int t;

    vecs[0] = '{13'h0000, 0, {NSYM{2'b00}}, "zeros"};
    vecs[1] = '{13'h1000, 0, {2'b11, 2'b10, 2'b11, {12{2'b00}}}, "msb"};
    vecs[2] = '{13'h1FFF, 0, {2'b11, 2'b01, {11{2'b10}}, 2'b01, 2'b11}, "ones"};
    vecs[3] = '{13'h0001, 0, {{12{2'b00}}, 2'b11, 2'b10, 2'b11}, "lsb"};
    vecs[4] = '{13'h1001, 0, {2'b11, 2'b10, 2'b11, {9{2'b00}}, 2'b11, 2'b10, 2'b11}, "msb_lsb"};
    vecs[5] = '{13'h1FFF, 6, {2'b11, 2'b01, {11{2'b10}}, 2'b01, 2'b11}, "ones_stall"};
    vecs[6] = '{13'h1000, 6, {2'b11, 2'b10, 2'b11, {12{2'b00}}}, "msb_stall"};

    rst         = 1'b1;
    valid_i     = 1'b0;
    data_i      = '0;
    sym_ready_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reset ready_o", 32'(ready_o), 0);
    check("reset sym_valid_o", 32'(sym_valid_o), 0);
    check("reset sym/flags", 32'({sym_o, frame_start_o, frame_end_o}), 0);
    rst = 1'b0;
    #1;
    check("ready before first edge", 32'(ready_o), 0);
    @(negedge clk);
    check("ready after release", 32'(ready_o), 1);

    for (int i = 0; i < 7; i++)
      run_frame(vecs[i].d, vecs[i].stall_at, vecs[i].exp, 1'b0, vecs[i].name);

    // Payload offered throughout a frame must be ignored; the next frame is
    // taken on the first edge after the final transfer.
    run_frame(13'h1000, 0, vecs[1].exp, 1'b1, "busy");
    run_frame(13'h1FFF, 0, vecs[2].exp, 1'b0, "after_busy");

    // Mid-frame reset while symbol 5 is on the output
    valid_i = 1'b1;
    data_i  = 13'h1FFF;
    @(negedge clk);
    valid_i = 1'b0;
    @(negedge clk);
    got = 0;
    t   = 0;
    while (got < 4 && t < 50) begin
      if (sym_valid_o) got++;
      @(negedge clk);
      t++;
    end
    check("abort reached sym5", 32'({sym_valid_o, sym_o}), 32'({1'b1, 2'b10}));
    rst = 1'b1;
    #1;
    check("abort async clear", 32'({sym_valid_o, sym_o, frame_start_o, frame_end_o}), 0);
    @(negedge clk);
    check("abort in reset", 32'({ready_o, sym_valid_o, sym_o, frame_start_o, frame_end_o}), 0);
    rst = 1'b0;
    @(negedge clk);
    check("abort ready after release", 32'(ready_o), 1);
    run_frame(13'h1000, 0, vecs[1].exp, 1'b0, "after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
